sound_scheduler: RTL and testbench

Arbitrates the game's sound players (jump, score-milestone, game-over) onto the single audio output pin. Game logic raises one-cycle event pulses; this block decides which sound plays, issues the one-cycle trigger pulse to that player, times the sound's duration, and muxes the selected player's square wave onto `audio_out`. It applies fixed priority, pre-emption, queuing of one pending score sound, and a silent gap between back-to-back sounds.

---
 rtl/sound_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_sound_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_scheduler.sv
// sound_scheduler
// Arbitrates the jump, score-milestone and game-over sound players onto the
// single audio pin. Fixed priority over > jump > score. A higher-priority
// request pre-empts the current sound, an equal one restarts it, and a score
// request arriving while jump plays (or during the silent gap) is held in a
// one-deep pending flag. A jump request during the gap is held the same way.
//
// Ports:
//   clk         in   system clock (50 MHz)
//   rst_n       in   synchronous active-low reset
//   game_reset  in   synchronous flush, same effect as rst_n
//   jump_evt    in   one-cycle jump request
//   score_evt   in   one-cycle score request
//   over_evt    in   one-cycle game-over request
//   mute        in   forces audio_out low, scheduling unaffected
//   jump_wave   in   jump player square wave
//   score_wave  in   score player square wave
//   over_wave   in   game-over player square wave
//   jump_go     out  registered one-cycle trigger to jump player
//   score_go    out  registered one-cycle trigger to score player
//   over_go     out  registered one-cycle trigger to game-over player
//   audio_out   out  registered audio pin
//   active_id   out  0 none, 1 jump, 2 score, 3 over
//   busy        out  high whenever the scheduler is not idle
module sound_scheduler #(
    parameter int DUR_W        = 24,
    parameter int JUMP_CYCLES  = 2500000,
    parameter int SCORE_CYCLES = 5000000,
    parameter int OVER_CYCLES  = 6400000,
    parameter int GAP_CYCLES   = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_reset,
    input  logic       jump_evt,
    input  logic       score_evt,
    input  logic       over_evt,
    input  logic       mute,
    input  logic       jump_wave,
    input  logic       score_wave,
    input  logic       over_wave,
    output logic       jump_go,
    output logic       score_go,
    output logic       over_go,
    output logic       audio_out,
    output logic [1:0] active_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] ID_NONE  = 2'd0;
    localparam logic [1:0] ID_JUMP  = 2'd1;
    localparam logic [1:0] ID_SCORE = 2'd2;
    localparam logic [1:0] ID_OVER  = 2'd3;

    // Counters hold "cycles remaining minus one" so that zero marks the last cycle.
    localparam logic [DUR_W-1:0] JUMP_LOAD  = DUR_W'(JUMP_CYCLES - 1);
    localparam logic [DUR_W-1:0] SCORE_LOAD = DUR_W'(SCORE_CYCLES - 1);
    localparam logic [DUR_W-1:0] OVER_LOAD  = DUR_W'(OVER_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LOAD   = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [DUR_W-1:0] cnt;
    logic             pend_jump;
    logic             pend_score;

    logic [1:0]       grant_id;
    logic             pend_jump_nxt;
    logic             pend_score_nxt;
    logic [DUR_W-1:0] grant_load;
    logic             sel_wave;

    // Grant decision for this cycle plus the resulting pending flags.
    // Granting over always wipes both flags; a score request that loses to
    // jump is remembered, one that loses to over is dropped.
    always_comb begin
        grant_id       = ID_NONE;
        pend_jump_nxt  = pend_jump;
        pend_score_nxt = pend_score;
        unique case (state)
            IDLE: begin
                if (over_evt)
                    grant_id = ID_OVER;
                else if (pend_jump || jump_evt)
                    grant_id = ID_JUMP;
                else if (pend_score || score_evt)
                    grant_id = ID_SCORE;

                if (grant_id == ID_OVER) begin
                    pend_jump_nxt  = 1'b0;
                    pend_score_nxt = 1'b0;
                end else begin
                    if (grant_id == ID_JUMP)
                        pend_jump_nxt = 1'b0;
                    if (grant_id == ID_SCORE)
                        pend_score_nxt = 1'b0;
                    else if (score_evt)
                        pend_score_nxt = 1'b1;
                end
            end
            PLAY: begin
                if (over_evt)
                    grant_id = ID_OVER;
                else if (active_id != ID_OVER) begin
                    if (jump_evt)
                        grant_id = ID_JUMP;
                    else if (score_evt && active_id == ID_SCORE)
                        grant_id = ID_SCORE;
                end

                if (grant_id == ID_OVER) begin
                    pend_jump_nxt  = 1'b0;
                    pend_score_nxt = 1'b0;
                end else if (grant_id == ID_SCORE) begin
                    pend_score_nxt = 1'b0;
                end else begin
                    if (grant_id == ID_JUMP)
                        pend_jump_nxt = 1'b0;
                    if (score_evt && active_id != ID_OVER)
                        pend_score_nxt = 1'b1;
                end
            end
            GAP: begin
                if (over_evt) begin
                    grant_id       = ID_OVER;
                    pend_jump_nxt  = 1'b0;
                    pend_score_nxt = 1'b0;
                end else begin
                    if (jump_evt)
                        pend_jump_nxt = 1'b1;
                    if (score_evt)
                        pend_score_nxt = 1'b1;
                end
            end
            default: begin
                grant_id = ID_NONE;
            end
        endcase
    end

    // Duration to load for whichever sound is being granted.
    always_comb begin
        unique case (grant_id)
            ID_JUMP:  grant_load = JUMP_LOAD;
            ID_SCORE: grant_load = SCORE_LOAD;
            ID_OVER:  grant_load = OVER_LOAD;
            default:  grant_load = '0;
        endcase
    end

    // Wave of the currently selected player; pre-empted players keep running
    // on their own but are simply not selected here.
    always_comb begin
        unique case (active_id)
            ID_JUMP:  sel_wave = jump_wave;
            ID_SCORE: sel_wave = score_wave;
            ID_OVER:  sel_wave = over_wave;
            default:  sel_wave = 1'b0;
        endcase
    end

    // Main FSM with registered trigger pulses, active id and audio pin.
    always_ff @(posedge clk) begin
        if (!rst_n || game_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_jump  <= 1'b0;
            pend_score <= 1'b0;
            jump_go    <= 1'b0;
            score_go   <= 1'b0;
            over_go    <= 1'b0;
            active_id  <= ID_NONE;
            audio_out  <= 1'b0;
        end else begin
            jump_go    <= 1'b0;
            score_go   <= 1'b0;
            over_go    <= 1'b0;
            pend_jump  <= pend_jump_nxt;
            pend_score <= pend_score_nxt;
            audio_out  <= sel_wave & (state == PLAY) & ~mute;

            if (grant_id != ID_NONE) begin
                state     <= PLAY;
                cnt       <= grant_load;
                active_id <= grant_id;
                jump_go   <= (grant_id == ID_JUMP);
                score_go  <= (grant_id == ID_SCORE);
                over_go   <= (grant_id == ID_OVER);
            end else begin
                unique case (state)
                    PLAY: begin
                        if (cnt == '0) begin
                            active_id <= ID_NONE;
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                                cnt   <= GAP_LOAD;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == '0)
                            state <= IDLE;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler
// Self-checking bench for sound_scheduler with short durations
// (jump 20, score 30, over 40, gap 4). Each scenario drives events on fixed
// cycles; the expected outputs for the following cycle are queued as the
// stimulus is driven and compared when that cycle is sampled.
module tb_sound_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game_reset;
    logic       jump_evt;
    logic       score_evt;
    logic       over_evt;
    logic       mute;
    logic       jump_wave;
    logic       score_wave;
    logic       over_wave;
    logic       jump_go;
    logic       score_go;
    logic       over_go;
    logic       audio_out;
    logic [1:0] active_id;
    logic       busy;

    typedef struct packed {
        logic       jump_go;
        logic       score_go;
        logic       over_go;
        logic [1:0] id;
        logic       busy;
        logic       audio;
    } exp_t;

    exp_t sb_q[$];
    int   check_count = 0;
    int   error_count = 0;
    int   cur_scen    = 0;
    int   cur_cyc     = 0;

    sound_scheduler #(
        .DUR_W       (24),
        .JUMP_CYCLES (20),
        .SCORE_CYCLES(30),
        .OVER_CYCLES (40),
        .GAP_CYCLES  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_reset(game_reset),
        .jump_evt  (jump_evt),
        .score_evt (score_evt),
        .over_evt  (over_evt),
        .mute      (mute),
        .jump_wave (jump_wave),
        .score_wave(score_wave),
        .over_wave (over_wave),
        .jump_go   (jump_go),
        .score_go  (score_go),
        .over_go   (over_go),
        .audio_out (audio_out),
        .active_id (active_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s scen=%0d cyc=%0d got=%0d expected=%0d",
                     tag, cur_scen, cur_cyc, actual, expected);
        end
    endtask

    // Hand-derived timeline of triggers, active id and busy per scenario.
    function automatic exp_t expectAt(input int s, input int c);
        exp_t e;
        e = '0;
        case (s)
            1: begin
                e.jump_go = (c == 11);
                if (c >= 11 && c <= 30) e.id = 2'd1;
                e.busy = (c >= 11 && c <= 34);
            end
            2: begin
                e.jump_go  = (c == 11);
                e.score_go = (c == 36);
                if (c >= 11 && c <= 30) e.id = 2'd1;
                if (c >= 36 && c <= 65) e.id = 2'd2;
                e.busy = (c >= 11 && c <= 34) || (c >= 36 && c <= 69);
            end
            3: begin
                e.score_go = (c == 11);
                e.jump_go  = (c == 21);
                if (c >= 11 && c <= 20) e.id = 2'd2;
                if (c >= 21 && c <= 40) e.id = 2'd1;
                e.busy = (c >= 11 && c <= 44);
            end
            4: begin
                e.over_go = (c == 11);
                if (c >= 11 && c <= 50) e.id = 2'd3;
                e.busy = (c >= 11 && c <= 54);
            end
            5: begin
                e.jump_go = (c == 11) || (c == 26);
                if (c >= 11 && c <= 45) e.id = 2'd1;
                e.busy = (c >= 11 && c <= 49);
            end
            6: begin
                e.over_go = (c == 11);
                if (c >= 11 && c <= 20) e.id = 2'd3;
                e.busy = (c >= 11 && c <= 20);
            end
            7: begin
                e.jump_go  = (c == 11) || (c == 36);
                e.score_go = (c == 61);
                if ((c >= 11 && c <= 30) || (c >= 36 && c <= 55)) e.id = 2'd1;
                if (c >= 61 && c <= 90) e.id = 2'd2;
                e.busy = (c >= 11 && c <= 34) || (c >= 36 && c <= 59) || (c >= 61 && c <= 94);
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Event, mute and flush inputs for scenario s in cycle c.
    task automatic applyStimulus(input int s, input int c);
        jump_evt   = 1'b0;
        score_evt  = 1'b0;
        over_evt   = 1'b0;
        mute       = 1'b0;
        game_reset = 1'b0;
        case (s)
            1: jump_evt = (c == 10);
            2: begin
                jump_evt  = (c == 10);
                score_evt = (c == 15);
            end
            3: begin
                score_evt = (c == 10);
                jump_evt  = (c == 20);
            end
            4: begin
                jump_evt  = (c == 10) || (c == 20);
                score_evt = (c == 10);
                over_evt  = (c == 10);
            end
            5: begin
                jump_evt = (c == 10) || (c == 25);
                mute     = (c >= 15 && c <= 20);
            end
            6: begin
                over_evt   = (c == 10);
                game_reset = (c == 20);
                score_evt  = (c == 20);
            end
            7: begin
                jump_evt  = (c == 10) || (c == 32);
                score_evt = (c == 33);
            end
            default: ;
        endcase
    endtask

    function automatic logic waveFor(input logic [1:0] id);
        case (id)
            2'd1:    return jump_wave;
            2'd2:    return score_wave;
            2'd3:    return over_wave;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compareNext();
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("jump_go",   jump_go,   e.jump_go);
            checkOutput("score_go",  score_go,  e.score_go);
            checkOutput("over_go",   over_go,   e.over_go);
            checkOutput("active_id", active_id, e.id);
            checkOutput("busy",      busy,      e.busy);
            checkOutput("audio_out", audio_out, e.audio);
        end
    endtask

    // Reset, then run cycles 0..last, queueing expected outputs for c+1.
    task automatic runScenario(input int s, input int last);
        exp_t cur;
        exp_t nxt;
        cur_scen = s;
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 0);
        repeat (2) @(negedge clk);
        cur_cyc = -1;
        checkOutput("rst_jump_go",  jump_go,   0);
        checkOutput("rst_score_go", score_go,  0);
        checkOutput("rst_over_go",  over_go,   0);
        checkOutput("rst_id",       active_id, 0);
        checkOutput("rst_busy",     busy,      0);
        checkOutput("rst_audio",    audio_out, 0);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            cur_cyc = c;
            compareNext();
            rst_n = 1'b1;
            applyStimulus(s, c);
            jump_wave  = 1'($urandom_range(0, 1));
            score_wave = 1'($urandom_range(0, 1));
            over_wave  = 1'($urandom_range(0, 1));
            cur = expectAt(s, c);
            nxt = expectAt(s, c + 1);
            nxt.audio = game_reset ? 1'b0
                                   : (waveFor(cur.id) & (cur.id != 2'd0) & ~mute);
            sb_q.push_back(nxt);
        end
        @(negedge clk);
        cur_cyc = last + 1;
        compareNext();
    endtask

    initial begin
        rst_n      = 1'b0;
        jump_wave  = 1'b0;
        score_wave = 1'b0;
        over_wave  = 1'b0;
        applyStimulus(0, 0);
        runScenario(1, 45);
        runScenario(2, 75);
        runScenario(3, 60);
        runScenario(4, 70);
        runScenario(5, 60);
        runScenario(6, 40);
        runScenario(7, 100);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
